// File: rtl/processor_mkiii.sv
// processor_mkiii: multi-cycle single-bus core (IDLE -> LOAD_A -> LOAD_B -> EXEC).
// Optional multiplier on opcode 14 is enabled by defining PROCESSOR_MKIII_MUL_EN.
module processor_mkiii #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int IMM_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       machine_code,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              retire,
   output logic              illegal,
   output logic [DATA_W-1:0] bus,
   input  logic [4:0]        dbg_index,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int SHW = $clog2(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_A = 2'd1,
      ST_LOAD_B = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic [3:0]        opcode_s;
   logic [4:0]        rd_s, rs1_s, rs2_s;
   logic [DATA_W-1:0] imm_sext_s, rs1_val_s, rs2_val_s, alu_s;
   logic              is_itype_s, is_li_s, legal_s, wen_s;

   assign opcode_s   = ir_q[31:28];
   assign rd_s       = ir_q[27:23];
   assign rs1_s      = ir_q[22:18];
   assign rs2_s      = ir_q[17:13];
   assign imm_sext_s = DATA_W'($signed(ir_q[IMM_W-1:0]));
   assign is_itype_s = (opcode_s == 4'd8) || (opcode_s == 4'd9);
   assign is_li_s    = (opcode_s == 4'd9);

   // Register read ports; index 0 and indices beyond NUM_REGS-1 read as zero.
   always_comb begin
      rs1_val_s = '0;
      rs2_val_s = '0;
      dbg_data  = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (rs1_s == 5'(i))     rs1_val_s = regs_q[i];
         if (rs2_s == 5'(i))     rs2_val_s = regs_q[i];
         if (dbg_index == 5'(i)) dbg_data  = regs_q[i];
      end
   end

   // ALU and opcode legality decode.
   always_comb begin
      alu_s   = '0;
      legal_s = 1'b1;
      case (opcode_s)
         4'd0:       alu_s = a_q + b_q;
         4'd1:       alu_s = a_q - b_q;
         4'd2:       alu_s = a_q & b_q;
         4'd3:       alu_s = a_q | b_q;
         4'd4:       alu_s = a_q ^ b_q;
         4'd5:       alu_s = a_q << b_q[SHW-1:0];
         4'd6:       alu_s = a_q >> b_q[SHW-1:0];
         4'd7:       alu_s = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         4'd8, 4'd9: alu_s = a_q + b_q;
`ifdef PROCESSOR_MKIII_MUL_EN
         4'd14:      alu_s = a_q * b_q;
`endif
         4'd15:      alu_s = '0;
         default:    legal_s = 1'b0;
      endcase
   end

   // Shared bus source selection per state.
   always_comb begin
      bus = '0;
      case (state_q)
         ST_IDLE:   bus = '0;
         ST_LOAD_A: bus = is_li_s ? '0 : rs1_val_s;
         ST_LOAD_B: bus = is_itype_s ? imm_sext_s : rs2_val_s;
         ST_EXEC:   bus = alu_s;
         default:   bus = '0;
      endcase
   end

   // Next-state and handshake/status outputs; reset suppresses any completion.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      instr_ready = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
      wen_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready = !reset;
            if (instr_valid) begin
               ir_d    = machine_code;
               state_d = ST_LOAD_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_A: begin
            a_d     = bus;
            state_d = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            b_d     = bus;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            retire  = !reset;
            illegal = !reset && !legal_s;
            wen_s   = !reset && legal_s && (opcode_s != 4'd15);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and operand state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ir_q    <= 32'd0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   // Register file writeback from the bus during EXEC; r0 is never written.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wen_s && (rd_s == 5'(i))) regs_q[i] <= bus;
         end
      end
   end

endmodule

// File: tb/tb_processor_mkiii.sv
// Directed self-checking bench for processor_mkiii (DATA_W=8, NUM_REGS=8).
module tb_processor_mkiii;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] machine_code;
   logic        instr_valid;
   logic        instr_ready;
   logic        retire;
   logic        illegal;
   logic [7:0]  bus;
   logic [4:0]  dbg_index;
   logic [7:0]  dbg_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   processor_mkiii #(.DATA_W(8), .NUM_REGS(8), .IMM_W(16)) dut (
      .clk(clk), .reset(reset), .machine_code(machine_code),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .retire(retire), .illegal(illegal), .bus(bus),
      .dbg_index(dbg_index), .dbg_data(dbg_data)
   );

   function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 13'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, 2'b00, imm};
   endfunction

   // Runs one instruction, recording retire/illegal cycle, busy ready, EXEC bus and cycle-4 ready.
   task automatic issue(input logic [31:0] code, output int ret_cyc, output int ill_cyc,
                        output logic busy_rdy, output logic [7:0] bus3, output logic rdy4);
      ret_cyc = -1; ill_cyc = -1; busy_rdy = 1'b0; bus3 = 8'd0; rdy4 = 1'b0;
      @(negedge clk);
      machine_code = code;
      instr_valid  = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) instr_valid = 1'b0;
         if (retire === 1'b1 && ret_cyc < 0) ret_cyc = c;
         if (illegal === 1'b1 && ill_cyc < 0) ill_cyc = c;
         if (c < 4 && instr_ready !== 1'b0) busy_rdy = 1'b1;
         if (c == 3) bus3 = bus;
         if (c == 4) rdy4 = instr_ready;
      end
   endtask

   task automatic read_reg(input logic [4:0] idx, output logic [7:0] val);
      @(negedge clk);
      dbg_index = idx;
      #1 val = dbg_data;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      reset = 1'b1; instr_valid = 1'b1; machine_code = enc_i(4'd9, 5'd1, 5'd0, 16'h0033);
      repeat (3) @(negedge clk);
      reset = 1'b0; instr_valid = 1'b0;
      #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL rst_retire got=%b exp=0", retire); end
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
      checks++; if (bus !== 8'h00) begin failures++; $display("FAIL rst_bus got=%h exp=00", bus); end
      read_reg(5'd1, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL rst_r1 got=%h exp=00", v); end
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready2 got=%b exp=1", instr_ready); end
   endtask

   task automatic test_basic();
      int rc, ic; logic br, r4; logic [7:0] b3, v;
      issue(enc_i(4'd9, 5'd1, 5'd0, 16'd5), rc, ic, br, b3, r4);
      checks++; if (rc !== 3) begin failures++; $display("FAIL li_retire_cycle got=%0d exp=3", rc); end
      checks++; if (br !== 1'b0) begin failures++; $display("FAIL li_busy_ready got=%b exp=0", br); end
      checks++; if (r4 !== 1'b1) begin failures++; $display("FAIL li_ready_c4 got=%b exp=1", r4); end
      checks++; if (ic !== -1) begin failures++; $display("FAIL li_illegal got=%0d exp=-1", ic); end
      checks++; if (b3 !== 8'h05) begin failures++; $display("FAIL li_r1_bus got=%h exp=05", b3); end
      issue(enc_i(4'd9, 5'd2, 5'd0, 16'hFFFD), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'hFD) begin failures++; $display("FAIL li_r2_bus got=%h exp=fd", b3); end
      issue(enc_r(4'd0, 5'd3, 5'd1, 5'd2), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h02) begin failures++; $display("FAIL add_bus got=%h exp=02", b3); end
      checks++; if (rc !== 3) begin failures++; $display("FAIL add_retire_cycle got=%0d exp=3", rc); end
      issue(enc_r(4'd1, 5'd4, 5'd1, 5'd2), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h08) begin failures++; $display("FAIL sub_bus got=%h exp=08", b3); end
      issue(enc_r(4'd7, 5'd5, 5'd2, 5'd1), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h01) begin failures++; $display("FAIL slt_bus got=%h exp=01", b3); end
      read_reg(5'd3, v);
      checks++; if (v !== 8'h02) begin failures++; $display("FAIL r3 got=%h exp=02", v); end
      read_reg(5'd4, v);
      checks++; if (v !== 8'h08) begin failures++; $display("FAIL r4 got=%h exp=08", v); end
      read_reg(5'd5, v);
      checks++; if (v !== 8'h01) begin failures++; $display("FAIL r5 got=%h exp=01", v); end
   endtask

   task automatic test_range();
      int rc, ic; logic br, r4; logic [7:0] b3, v;
      issue(enc_i(4'd9, 5'd0, 5'd0, 16'd7), rc, ic, br, b3, r4);
      read_reg(5'd0, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL r0_write got=%h exp=00", v); end
      issue(enc_i(4'd9, 5'd9, 5'd0, 16'd7), rc, ic, br, b3, r4);
      checks++; if (rc !== 3 || ic !== -1) begin failures++; $display("FAIL r9_li_status got=%0d/%0d exp=3/-1", rc, ic); end
      read_reg(5'd9, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL r9_read got=%h exp=00", v); end
      issue(enc_r(4'd0, 5'd1, 5'd9, 5'd0), rc, ic, br, b3, r4);
      read_reg(5'd1, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL r1_from_r9 got=%h exp=00", v); end
      issue(enc_i(4'd9, 5'd7, 5'd0, 16'h0011), rc, ic, br, b3, r4);
      read_reg(5'd7, v);
      checks++; if (v !== 8'h11) begin failures++; $display("FAIL r7_top_index got=%h exp=11", v); end
   endtask

   task automatic test_illegal();
      int rc, ic; logic br, r4; logic [7:0] b3, v;
      issue(enc_r(4'd12, 5'd2, 5'd1, 5'd1), rc, ic, br, b3, r4);
      checks++; if (rc !== 3) begin failures++; $display("FAIL ill12_retire got=%0d exp=3", rc); end
      checks++; if (ic !== 3) begin failures++; $display("FAIL ill12_illegal got=%0d exp=3", ic); end
      read_reg(5'd2, v);
      checks++; if (v !== 8'hFD) begin failures++; $display("FAIL ill12_r2 got=%h exp=fd", v); end
      issue(enc_i(4'd9, 5'd6, 5'd0, 16'd6), rc, ic, br, b3, r4);
      issue(enc_i(4'd9, 5'd7, 5'd0, 16'd7), rc, ic, br, b3, r4);
      issue(enc_r(4'd14, 5'd2, 5'd6, 5'd7), rc, ic, br, b3, r4);
      read_reg(5'd2, v);
`ifdef PROCESSOR_MKIII_MUL_EN
      checks++; if (ic !== -1) begin failures++; $display("FAIL mul_illegal got=%0d exp=-1", ic); end
      checks++; if (v !== 8'd42) begin failures++; $display("FAIL mul_r2 got=%h exp=2a", v); end
`else
      checks++; if (ic !== 3) begin failures++; $display("FAIL op14_illegal got=%0d exp=3", ic); end
      checks++; if (v !== 8'hFD) begin failures++; $display("FAIL op14_r2 got=%h exp=fd", v); end
`endif
      issue(enc_r(4'd15, 5'd2, 5'd6, 5'd7), rc, ic, br, b3, r4);
      checks++; if (rc !== 3 || ic !== -1) begin failures++; $display("FAIL nop_status got=%0d/%0d exp=3/-1", rc, ic); end
   endtask

   task automatic test_wrap_shift();
      int rc, ic; logic br, r4; logic [7:0] b3, v;
      issue(enc_i(4'd9, 5'd1, 5'd0, 16'h007F), rc, ic, br, b3, r4);
      issue(enc_i(4'd8, 5'd1, 5'd1, 16'd1), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h80) begin failures++; $display("FAIL addi_wrap got=%h exp=80", b3); end
      issue(enc_i(4'd9, 5'd2, 5'd0, 16'd9), rc, ic, br, b3, r4);
      issue(enc_i(4'd9, 5'd3, 5'd0, 16'd3), rc, ic, br, b3, r4);
      issue(enc_r(4'd5, 5'd4, 5'd3, 5'd2), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h06) begin failures++; $display("FAIL sll9 got=%h exp=06", b3); end
      issue(enc_r(4'd6, 5'd5, 5'd1, 5'd2), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h40) begin failures++; $display("FAIL srl9 got=%h exp=40", b3); end
      issue(enc_r(4'd7, 5'd6, 5'd1, 5'd3), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h01) begin failures++; $display("FAIL slt_neg got=%h exp=01", b3); end
      issue(enc_r(4'd4, 5'd7, 5'd1, 5'd3), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h83) begin failures++; $display("FAIL xor got=%h exp=83", b3); end
      issue(enc_r(4'd3, 5'd7, 5'd2, 5'd3), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h0B) begin failures++; $display("FAIL or got=%h exp=0b", b3); end
      issue(enc_r(4'd2, 5'd6, 5'd2, 5'd3), rc, ic, br, b3, r4);
      checks++; if (b3 !== 8'h01) begin failures++; $display("FAIL and got=%h exp=01", b3); end
      read_reg(5'd1, v);
      checks++; if (v !== 8'h80) begin failures++; $display("FAIL r1_wrap got=%h exp=80", v); end
   endtask

   task automatic test_reset_abort();
      int rc, ic; logic br, r4; logic [7:0] b3, v;
      @(negedge clk);
      machine_code = enc_r(4'd0, 5'd3, 5'd1, 5'd2);
      instr_valid  = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1; instr_valid = 1'b1; machine_code = enc_i(4'd9, 5'd1, 5'd0, 16'h0055);
      @(negedge clk);
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL abort_retire got=%b exp=0", retire); end
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_in_reset got=%b exp=0", instr_ready); end
      @(negedge clk);
      reset = 1'b0; instr_valid = 1'b0;
      #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", instr_ready); end
      checks++; if (bus !== 8'h00) begin failures++; $display("FAIL abort_bus got=%h exp=00", bus); end
      read_reg(5'd3, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL abort_r3 got=%h exp=00", v); end
      read_reg(5'd1, v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL abort_r1 got=%h exp=00", v); end
      issue(enc_i(4'd9, 5'd1, 5'd0, 16'h0021), rc, ic, br, b3, r4);
      checks++; if (rc !== 3) begin failures++; $display("FAIL post_abort_retire got=%0d exp=3", rc); end
      read_reg(5'd1, v);
      checks++; if (v !== 8'h21) begin failures++; $display("FAIL post_abort_r1 got=%h exp=21", v); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [3];
      logic [7:0]  v;
      prog[0] = enc_i(4'd9, 5'd6, 5'd0, 16'd3);
      prog[1] = enc_r(4'd0, 5'd7, 5'd6, 5'd6);
      prog[2] = enc_r(4'd0, 5'd7, 5'd7, 5'd6);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 4 == 0) begin
            machine_code = prog[c / 4];
            instr_valid  = 1'b1;
         end
         if (c == 9) instr_valid = 1'b0;
         checks++; if (instr_ready !== (c % 4 == 0)) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, instr_ready, (c % 4 == 0)); end
         checks++; if (retire !== (c % 4 == 3)) begin failures++; $display("FAIL b2b_retire c=%0d got=%b exp=%b", c, retire, (c % 4 == 3)); end
         if (c == 7) begin
            checks++; if (bus !== 8'd6) begin failures++; $display("FAIL b2b_bus7 got=%h exp=06", bus); end
         end
         if (c == 11) begin
            checks++; if (bus !== 8'd9) begin failures++; $display("FAIL b2b_bus11 got=%h exp=09", bus); end
         end
      end
      read_reg(5'd7, v);
      checks++; if (v !== 8'd9) begin failures++; $display("FAIL b2b_r7 got=%h exp=09", v); end
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; machine_code = 32'd0; dbg_index = 5'd0;
      test_reset();
      test_basic();
      test_range();
      test_illegal();
      test_wrap_shift();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
